// File: rtl/div_pkg.sv
// Shared defines for the divider: bus widths, handshake levels and FSM state encodings.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic              RstEnable         = 1'b1;
  localparam logic [RegBus-1:0] ZeroWord          = 32'h0000_0000;
  localparam logic              DivResultReady    = 1'b1;
  localparam logic              DivResultNotReady = 1'b0;
  localparam logic              DivStart          = 1'b1;
  localparam logic              DivStop           = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  // Absolute value of an operand when treated as signed, raw value otherwise.
  function automatic logic [RegBus-1:0] magnitude(input logic is_signed,
                                                  input logic [RegBus-1:0] v);
    return (is_signed && v[RegBus-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div.sv
// Iterative 32/32 restoring divider: ready_o 34 edges after start (2 for divide-by-zero).
// Requester holds start_i until ready_o; result is held in DivEnd until start_i drops.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_t              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [DoubleRegBus:0]   dividend_q, dividend_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    signed_q, signed_d;
  logic                    neg1_q, neg1_d;
  logic                    neg2_q, neg2_d;
  logic [DoubleRegBus-1:0] result_d;
  logic                    ready_d;

  logic [DoubleRegBus:0]   shifted;
  logic [RegBus:0]         trial;
  logic                    trial_ok;
  logic [RegBus-1:0]       quo_fix, rem_fix;

  // A set bit 64 would mean the shifted remainder exceeds any 32-bit divisor.
  assign shifted  = {dividend_q[DoubleRegBus-1:0], 1'b0};
  assign trial    = shifted[DoubleRegBus:RegBus] - {1'b0, divisor_q};
  assign trial_ok = ~trial[RegBus] | dividend_q[DoubleRegBus];

  assign quo_fix = (signed_q && (neg1_q ^ neg2_q)) ? -dividend_q[RegBus-1:0]
                                                   :  dividend_q[RegBus-1:0];
  assign rem_fix = (signed_q && neg1_q) ? -dividend_q[DoubleRegBus-1:RegBus]
                                        :  dividend_q[DoubleRegBus-1:RegBus];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    signed_d   = signed_q;
    neg1_d     = neg1_q;
    neg2_d     = neg2_q;
    result_d   = result_o;
    ready_d    = ready_o;

    case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = {ZeroWord, ZeroWord};
        if (start_i == DivStart && !annul_i) begin
          signed_d   = signed_div_i;
          neg1_d     = signed_div_i & opdata1_i[RegBus-1];
          neg2_d     = signed_div_i & opdata2_i[RegBus-1];
          dividend_d = {{(RegBus+1){1'b0}}, magnitude(signed_div_i, opdata1_i)};
          divisor_d  = magnitude(signed_div_i, opdata2_i);
          cnt_d      = 6'd0;
          state_d    = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
        end
      end

      DivByZero: begin
        state_d  = DivEnd;
        result_d = {ZeroWord, ZeroWord};
        ready_d  = DivResultReady;
      end

      DivOn: begin
        if (annul_i) begin
          state_d  = DivFree;
          cnt_d    = 6'd0;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end else if (cnt_q != 6'd32) begin
          dividend_d = trial_ok ? {trial, shifted[RegBus-1:1], 1'b1} : shifted;
          cnt_d      = cnt_q + 6'd1;
        end else begin
          state_d  = DivEnd;
          cnt_d    = 6'd0;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end

      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = {ZeroWord, ZeroWord};
        end else begin
          ready_d  = DivResultReady;
        end
      end

      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      dividend_q <= '0;
      divisor_q  <= ZeroWord;
      signed_q   <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_o   <= {ZeroWord, ZeroWord};
      ready_o    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      signed_q   <= signed_d;
      neg1_q     <= neg1_d;
      neg2_q     <= neg2_d;
      result_o   <= result_d;
      ready_o    <= ready_d;
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset (`RstEnable = 1'b1`), sampled on the rising clk edge.
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 = signed division, 0 = unsigned division.
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend.
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor.
REQ-006 SHALL have port start_i, input, 1 bit: `DivStart` requests a division; the requester holds it until it sees ready.
REQ-007 SHALL have port annul_i, input, 1 bit: abort the operation in progress (exception or flush).
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}; the execute stage writes the remainder to HI and the quotient to LO.
REQ-009 SHALL have port ready_o, output, 1 bit: `DivResultReady` means result_o is valid.

Function
REQ-010 SHALL implement a 4-state FSM with states DivFree, DivByZero, DivOn and DivEnd; all outputs are registered.
REQ-011 In DivFree with start_i=DivStart and annul_i=0: SHALL latch signed_div_i, both operand sign bits and the operand magnitudes, then go to DivByZero if opdata2_i==0, otherwise to DivOn with cnt=0.
- Magnitude = two's-complement negation when signed and bit31=1; raw value otherwise.
REQ-012 In DivFree with start_i=DivStop, or with annul_i=1: SHALL remain in DivFree, with ready_o=0 and result_o=0.
REQ-013 DivByZero SHALL go to DivEnd on the next edge, with result_o=64'h0 and ready_o=1.
REQ-014 DivOn, while cnt!=32: SHALL perform one restoring step per cycle on a 65-bit {partial remainder, dividend} register.
- Shift left by 1.
- Trial-subtract the divisor from the upper 33 bits.
- If the result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
- Increment the 6-bit cnt.
REQ-015 DivOn, when cnt==32: SHALL go to DivEnd and set ready_o=1.
- Quotient is negated iff signed and the operand signs differ.
- Remainder is negated iff signed and the dividend is negative.
- result_o = {remainder, quotient}.
REQ-016 Latency: ready_o SHALL rise on the 34th rising edge counted from (and including) the edge that accepts start; for divide-by-zero, on the 2nd edge.
REQ-017 DivEnd: SHALL hold result_o and ready_o=1 while start_i=DivStart; when start_i=DivStop, go to DivFree on the next edge with ready_o=0 and result_o=0.
REQ-018 annul_i=1 in DivOn SHALL go to DivFree on the next edge with cnt=0, ready_o=0 and result_o=0; no result is produced.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0, with no trap.
REQ-020 A new start_i in the same cycle that DivEnd returns to DivFree SHALL NOT be accepted until the FSM is in DivFree.

Reset
REQ-021 rst=1 on an edge SHALL force state=DivFree, cnt=0, ready_o=DivResultNotReady and result_o=64'h0, overriding any state including mid-DivOn.
REQ-022 After rst deasserts, the block SHALL accept start on the first edge.

Structure
REQ-023 The following SHALL live in the shared defines file:
- State encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
- DivResultReady/DivResultNotReady, DivStart/DivStop.
- RstEnable, ZeroWord, RegBus, DoubleRegBus.
REQ-024 SHALL be a single module; no sub-module, with the trial-subtract datapath inline; it is instantiated beside the execute stage and fed by its div_* outputs.

Verification
REQ-025 Unsigned 100 / 7, start held -> ready_o=1 at edge 34; result_o=64'h00000002_0000000E.
REQ-026 Signed -7 (0xFFFFFFF9) / 2 -> result_o=64'hFFFFFFFF_FFFFFFFD; unsigned with the same operands -> quotient 0x7FFFFFFC, remainder 1.
REQ-027 Divisor 0, start held -> ready_o=1 at edge 2, result_o=0; start dropped -> DivFree, ready_o=0 next cycle.
REQ-028 annul_i pulsed at cnt=10 -> ready_o never rises, FSM in DivFree; a following 9/3 completes with quotient 3, remainder 0.
REQ-029 rst asserted at cnt=20 -> next cycle ready_o=0, result_o=0; a subsequent signed 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000.
REQ-030 Back-to-back divisions, start dropped for one cycle after ready -> second result correct; ready_o high for exactly the cycles start stays asserted in DivEnd.
